// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO accepts bytes over a
// valid/ready handshake and a serializer drains it onto uart_tx, LSB first.
// Consecutive queued bytes leave the line with no idle gap between frames.
module uart_tx_fifo #(
    parameter int clk_per_bit = 217,
    parameter int fifo_depth  = 8,
    parameter int data_width  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [data_width-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          uart_tx
);

    localparam int PTR_W  = $clog2(fifo_depth);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(clk_per_bit);
    localparam int IDX_W  = $clog2(data_width);

    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(fifo_depth);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clk_per_bit - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(data_width - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_reg;
    logic [data_width-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [BAUD_W-1:0]     baud_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [data_width-1:0] shift_reg;
    logic                  uart_tx_reg;

    logic push;
    logic pop;
    logic bit_done;
    logic have_data;

    assign have_data = (count_reg != '0);
    assign bit_done  = (baud_reg == BAUD_LAST);

    // Ready is gated by reset so nothing slips into the FIFO while held in reset;
    // a full FIFO refuses pushes even on a cycle that also pops.
    assign tx_ready = (count_reg < DEPTH) && reset;
    assign push     = tx_valid && tx_ready;

    // The head byte leaves the FIFO when an idle serializer sees data, or when
    // a stop bit finishes with more data waiting (back-to-back frames).
    always_comb begin
        pop = 1'b0;
        if (have_data) begin
            if (state_reg == IDLE) begin
                pop = 1'b1;
            end else if (state_reg == STOP && bit_done) begin
                pop = 1'b1;
            end
        end
    end

    assign tx_busy    = (state_reg != IDLE) || have_data;
    assign fifo_count = count_reg;
    assign uart_tx    = uart_tx_reg;

    // FIFO storage: write-only array, read through the registered shift load.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Serializer FSM; uart_tx is loaded with the level of the state being entered
    // so the line changes on the same edge as the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            uart_tx_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_reg    <= '0;
                    uart_tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg   <= mem[rd_ptr_reg];
                        state_reg   <= START;
                        uart_tx_reg <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_reg    <= '0;
                        idx_reg     <= '0;
                        state_reg   <= DATA;
                        uart_tx_reg <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_reg <= '0;
                        if (idx_reg == IDX_LAST) begin
                            state_reg   <= STOP;
                            uart_tx_reg <= 1'b1;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            uart_tx_reg <= shift_reg[1];
                            idx_reg     <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_reg <= '0;
                        if (pop) begin
                            shift_reg   <= mem[rd_ptr_reg];
                            state_reg   <= START;
                            uart_tx_reg <= 1'b0;
                        end else begin
                            state_reg   <= IDLE;
                            uart_tx_reg <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    baud_reg    <= '0;
                    uart_tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with clk_per_bit=4, fifo_depth=8.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx_fifo;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [3:0] fifo_count;
    logic       uart_tx;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // Line decoder state
    logic [7:0] rx_q[$];
    int         start_times[$];
    int         n_starts  = 0;
    int         frame_err = 0;
    int         max_count = 0;

    uart_tx_fifo #(
        .clk_per_bit(4),
        .fifo_depth (8),
        .data_width (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count),
        .uart_tx   (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle counter for timing measurements
    always @(posedge clock) cyc++;

    // Track peak FIFO occupancy
    always @(negedge clock) begin
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, tx_busy}, 32'd0);
    endtask

    // Frame decoder: sample each bit near its middle (4 clocks per bit)
    initial begin
        logic [7:0] rx_byte;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                start_times.push_back(cyc);
                n_starts++;
                repeat (6) @(negedge clock);
                rx_byte[0] = uart_tx;
                for (int b = 1; b < 8; b++) begin
                    repeat (4) @(negedge clock);
                    rx_byte[b] = uart_tx;
                end
                repeat (4) @(negedge clock);
                if (uart_tx !== 1'b1) frame_err++;
                rx_q.push_back(rx_byte);
            end
        end
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         idx;
        int         guard;
        int         full_seen;
        int         bad_ready;
        int         low_cycles;
        int         n_before;
        logic [7:0] exp_b;
        logic [7:0] exp_list[5];

        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h77;

        // 1: held reset with tx_valid asserted
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_ready", {31'd0, tx_ready}, 32'd0);
            check("rst_count", {28'd0, fifo_count}, 32'd0);
            check("rst_line", {31'd0, uart_tx}, 32'd1);
            check("rst_busy", {31'd0, tx_busy}, 32'd0);
        end
        tx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("rel_ready", {31'd0, tx_ready}, 32'd1);
        repeat (20) @(negedge clock);
        check("rel_nostart", n_starts, 0);
        check("rel_count", {28'd0, fifo_count}, 32'd0);
        check("rel_line", {31'd0, uart_tx}, 32'd1);

        // 2: single byte 0xA5, cycle-exact waveform
        exp_b    = 8'hA5;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check("a5_count1", {28'd0, fifo_count}, 32'd1);
        check("a5_line_e0", {31'd0, uart_tx}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k <= 4) check("a5_start", {31'd0, uart_tx}, 32'd0);
            else if (k <= 36) check("a5_data", {31'd0, uart_tx}, {31'd0, exp_b[(k-5)/4]});
            else check("a5_stop", {31'd0, uart_tx}, 32'd1);
            if (k == 1) check("a5_count0", {28'd0, fifo_count}, 32'd0);
            if (k == 40) check("a5_busy_last", {31'd0, tx_busy}, 32'd1);
        end
        @(negedge clock);
        check("a5_busy_fall", {31'd0, tx_busy}, 32'd0);
        check("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("a5_rx", {24'd0, rx_q[0]}, 32'hA5);

        // 3: three bytes on consecutive cycles
        rx_q.delete();
        frame_err = 0;
        max_count = 0;
        base      = start_times.size();
        tx_valid  = 1'b1;
        tx_data   = 8'h00;
        @(negedge clock);
        tx_data = 8'hFF;
        @(negedge clock);
        tx_data = 8'h55;
        @(negedge clock);
        tx_valid = 1'b0;
        check("b2b_count2", {28'd0, fifo_count}, 32'd2);
        wait_idle(300, "b2b_idle");
        check("b2b_starts", start_times.size() - base, 3);
        if (start_times.size() - base == 3) begin
            check("b2b_total", cyc - start_times[base], 120);
            check("b2b_gap1", start_times[base+1] - start_times[base], 40);
            check("b2b_gap2", start_times[base+2] - start_times[base+1], 40);
        end
        check("b2b_peak", max_count, 2);
        check("b2b_rx_n", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b_rx0", {24'd0, rx_q[0]}, 32'h00);
            check("b2b_rx1", {24'd0, rx_q[1]}, 32'hFF);
            check("b2b_rx2", {24'd0, rx_q[2]}, 32'h55);
        end
        check("b2b_frame", frame_err, 0);

        // 4: continuous valid with 12 bytes, exercising full
        rx_q.delete();
        frame_err = 0;
        max_count = 0;
        idx       = 0;
        guard     = 0;
        full_seen = 0;
        bad_ready = 0;
        while (idx < 12 && guard < 1000) begin
            tx_valid = 1'b1;
            tx_data  = 8'(8'h10 + idx);
            if (!tx_ready && fifo_count != 4'd8) bad_ready++;
            if (!tx_ready) full_seen++;
            if (tx_ready) idx++;
            @(negedge clock);
            guard++;
        end
        tx_valid = 1'b0;
        check("full_pushed", idx, 12);
        check("full_peak", max_count, 8);
        check("full_seen", {31'd0, full_seen != 0}, 32'd1);
        check("full_ready", bad_ready, 0);
        wait_idle(700, "full_idle");
        check("full_rx_n", rx_q.size(), 12);
        if (rx_q.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check("full_rx", {24'd0, rx_q[i]}, 32'(8'h10 + i));
            end
        end
        check("full_frame", frame_err, 0);

        // 5: reset during data bit 3 of 0x3C with two bytes queued
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clock);
        tx_data = 8'h11;
        @(negedge clock);
        tx_data = 8'h22;
        @(negedge clock);
        tx_valid = 1'b0;
        check("mid_count2", {28'd0, fifo_count}, 32'd2);
        n_before = n_starts;
        repeat (7) @(negedge clock);
        check("mid_bit1", {31'd0, uart_tx}, 32'd0);
        repeat (8) @(negedge clock);
        check("mid_bit3", {31'd0, uart_tx}, 32'd1);
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_line", {31'd0, uart_tx}, 32'd1);
        check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_ready", {31'd0, tx_ready}, 32'd0);
        reset      = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) low_cycles++;
        end
        check("mid_quiet", low_cycles, 0);
        check("mid_nostart", n_starts, n_before);
        check("mid_idle_count", {28'd0, fifo_count}, 32'd0);
        rx_q.delete();

        // 6: push on the edge where STOP ends and pops, with three queued
        frame_err   = 0;
        exp_list[0] = 8'hA0;
        exp_list[1] = 8'hA1;
        exp_list[2] = 8'hA2;
        exp_list[3] = 8'hA3;
        exp_list[4] = 8'hA4;
        tx_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = exp_list[i];
            @(negedge clock);
        end
        tx_valid = 1'b0;
        check("sim_count3", {28'd0, fifo_count}, 32'd3);
        repeat (37) @(negedge clock);
        check("sim_pre_count", {28'd0, fifo_count}, 32'd3);
        check("sim_pre_stop", {31'd0, uart_tx}, 32'd1);
        tx_data  = exp_list[4];
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check("sim_post_count", {28'd0, fifo_count}, 32'd3);
        check("sim_post_start", {31'd0, uart_tx}, 32'd0);
        wait_idle(400, "sim_idle");
        check("sim_rx_n", rx_q.size(), 5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("sim_rx", {24'd0, rx_q[i]}, {24'd0, exp_list[i]});
            end
        end
        check("sim_frame", frame_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter. It sits directly downstream of the Wishbone-to-UART bridge and drives the top-level uart_tx pin. The bridge pushes bytes over a valid/ready handshake into an internal FIFO. A serializer FSM drains the FIFO and emits 8N1 frames, LSB first, with each bit lasting clk_per_bit clocks.

Parameters:
clk_per_bit, 217, clocks per UART bit (115200 baud at 25 MHz); must be >= 2.
fifo_depth, 8, FIFO entries; must be a power of 2 and >= 2.
data_width, 8, bits per character; fixed at 8 for 8N1.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset; asserted when reset==0.
tx_data  in  8  byte to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  FIFO can accept a byte this cycle.
tx_busy  out  1  a frame is in progress or the FIFO is non-empty.
fifo_count  out  $clog2(fifo_depth)+1  number of bytes queued, not counting the byte being shifted.
uart_tx  out  1  serial line output; idles high.

Behaviour:
- Reset (sampled on clock edge with reset==0):
  - FIFO pointers and fifo_count are cleared to 0.
  - FSM returns to IDLE and the baud counter is cleared.
  - uart_tx=1 and tx_busy=0.
  - tx_ready is forced to 0 while reset==0, so no push is accepted during reset.
- Push:
  - A push is accepted on an edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count < fifo_depth) && reset. It is combinational from registered state.
  - Pushes are never accepted when full, even if a pop occurs in the same cycle.
  - Read and write pointers wrap modulo fifo_depth.
  - Simultaneous push and pop leaves fifo_count unchanged.
- Baud counter:
  - Counts 0..clk_per_bit-1 and is cleared on every state entry.
  - A bit ends on the edge where the counter equals clk_per_bit-1.
- FSM states:
  - IDLE: uart_tx=1. If fifo_count>0, pop the head byte into a shift register and go to START.
  - START: uart_tx=0 for clk_per_bit clocks, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for clk_per_bit clocks, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: uart_tx=1 for clk_per_bit clocks. At the end, if fifo_count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- uart_tx is a registered output.
- Latency:
  - A push accepted on edge E0 into an empty, idle block causes a pop on edge E1.
  - uart_tx goes low after E1.
  - One frame = 10*clk_per_bit clocks.
  - Back-to-back frames are exactly 10*clk_per_bit apart.
- tx_busy = (state != IDLE) || (fifo_count != 0). It deasserts on the edge that enters IDLE with an empty FIFO.
- Reset mid-frame: the frame is truncated. uart_tx=1 after the reset edge, queued bytes are discarded, and no partial frame resumes.
- tx_data is not sampled unless the push handshake completes. tx_data and tx_valid are don't-care while tx_ready==0.

Test Plan:
(All scenarios use clk_per_bit=4, fifo_depth=8.)
1. Hold reset=0 for 3 cycles with tx_valid=1 -> tx_ready=0, fifo_count=0, uart_tx=1, tx_busy=0 throughout; no byte is transmitted after release.
2. Push 0xA5 once -> uart_tx low for 4 cycles starting 1 cycle after accept, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high for 4 cycles; tx_busy falls 40 cycles after the start bit began.
3. Push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames totalling 120 cycles; no idle cycles between stop and start; fifo_count peaks at 2.
4. Hold tx_valid=1 with 12 incrementing bytes 0x10..0x1B -> fifo_count never exceeds 8; tx_ready=0 while count==8; all 12 bytes appear on uart_tx in order.
5. With 0x3C shifting and 2 bytes queued, assert reset during DATA bit 3 -> uart_tx=1 the edge after reset; fifo_count=0; no further start bits after release.
6. With fifo_count=3 mid-frame, push on the same edge STOP ends and pops -> fifo_count stays 3; the pushed byte is transmitted 4th in order.
